// File: rtl/hazard_ctrl_tracked.sv
// Hazard controller for a 5-stage pipeline: tracks E/M/W destination tags and
// produces forwarding selects, load-use stalls, branch flushes and multi-cycle E stalls.
module hazard_ctrl_tracked #(
    parameter int REG_ADDR_W  = 4,
    parameter int NUM_SRC     = 2,
    parameter int MUL_LAT     = 3,
    parameter int ZERO_REG_EN = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]  RaD,
    input  logic [REG_ADDR_W-1:0]          WA3D,
    input  logic                           RegWriteD,
    input  logic                           MemtoRegD,
    input  logic                           MultiD,
    input  logic                           BranchTakenE,
    output logic [NUM_SRC*2-1:0]           ForwardE,
    output logic                           StallF,
    output logic                           StallD,
    output logic                           StallE,
    output logic                           FlushD,
    output logic                           FlushE,
    output logic                           FlushM
);

    localparam int CNT_W = $clog2(MUL_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT > 1 ? MUL_LAT - 1 : 0);

    logic [REG_ADDR_W-1:0] ra_e [NUM_SRC];
    logic [REG_ADDR_W-1:0] wa3_e, wa3_m, wa3_w;
    logic                  reg_write_e, mem_to_reg_e, reg_write_m, reg_write_w;
    logic [CNT_W-1:0]      cnt;

    logic                  busy, lwstall, lw_hit, flush_e;
    logic [NUM_SRC*2-1:0]  fwd;

    function automatic logic tag_match(input logic [REG_ADDR_W-1:0] a,
                                       input logic [REG_ADDR_W-1:0] b,
                                       input logic                  we);
        return we && (a == b) && !((ZERO_REG_EN != 0) && (a == '0));
    endfunction

    assign busy = (cnt != '0);

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        fwd    = '0;
        lw_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (tag_match(ra_e[i], wa3_m, reg_write_m))
                fwd[2*i +: 2] = 2'b10;
            else if (tag_match(ra_e[i], wa3_w, reg_write_w))
                fwd[2*i +: 2] = 2'b01;
            if (tag_match(RaD[i*REG_ADDR_W +: REG_ADDR_W], wa3_e, 1'b1))
                lw_hit = 1'b1;
        end
        lwstall = !busy && mem_to_reg_e && reg_write_e && lw_hit;
    end

    assign flush_e = !busy && (lwstall || BranchTakenE);

    // Outputs are forced low for the whole time reset is asserted.
    assign ForwardE = reset ? '0 : fwd;
    assign StallF   = !reset && (lwstall || busy);
    assign StallD   = !reset && (lwstall || busy);
    assign StallE   = !reset && busy;
    assign FlushM   = !reset && busy;
    assign FlushE   = !reset && flush_e;
    assign FlushD   = !reset && !busy && BranchTakenE;

    // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the tag array is small control state, so it is reset like everything else.
            for (int i = 0; i < NUM_SRC; i++) ra_e[i] <= '0;
            wa3_e        <= '0;
            reg_write_e  <= 1'b0;
            mem_to_reg_e <= 1'b0;
            wa3_m        <= '0;
            reg_write_m  <= 1'b0;
            wa3_w        <= '0;
            reg_write_w  <= 1'b0;
            cnt          <= '0;
        end else begin
            wa3_w       <= wa3_m;
            reg_write_w <= reg_write_m;
            if (busy) begin
                wa3_m       <= '0;
                reg_write_m <= 1'b0;
                cnt         <= cnt - 1'b1;
            end else begin
                wa3_m       <= wa3_e;
                reg_write_m <= reg_write_e;
                if (flush_e) begin
                    for (int i = 0; i < NUM_SRC; i++) ra_e[i] <= '0;
                    wa3_e        <= '0;
                    reg_write_e  <= 1'b0;
                    mem_to_reg_e <= 1'b0;
                    cnt          <= '0;
                end else begin
                    for (int i = 0; i < NUM_SRC; i++)
                        ra_e[i] <= RaD[i*REG_ADDR_W +: REG_ADDR_W];
                    wa3_e        <= WA3D;
                    reg_write_e  <= RegWriteD;
                    mem_to_reg_e <= MemtoRegD;
                    cnt          <= MultiD ? CNT_LOAD : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_tracked.sv
// Directed bench for hazard_ctrl_tracked (MUL_LAT=3, zero register enabled):
// expected outputs are queued with each step and checked mid-cycle.
module tb_hazard_ctrl_tracked;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] RaD;
    logic [3:0] WA3D;
    logic       RegWriteD, MemtoRegD, MultiD, BranchTakenE;
    logic [3:0] ForwardE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [9:0] exp_q [$];
    string      tag_q [$];

    // control field order: StallF StallD StallE FlushD FlushE FlushM
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LW   = 6'b110010;
    localparam logic [5:0] C_BUSY = 6'b111001;
    localparam logic [5:0] C_BRLW = 6'b110110;

    hazard_ctrl_tracked #(
        .REG_ADDR_W(4), .NUM_SRC(2), .MUL_LAT(3), .ZERO_REG_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .RaD(RaD), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MultiD(MultiD),
        .BranchTakenE(BranchTakenE), .ForwardE(ForwardE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic [3:0] ra0, input logic [3:0] ra1,
                        input logic [3:0] wa, input logic rw, input logic mtr,
                        input logic mul, input logic br,
                        input logic [3:0] fwd, input logic [5:0] ctl, input string tag);
        logic [9:0] obs, expv;
        string      t;
        @(negedge clk);
        reset        = rst;
        RaD          = {ra1, ra0};
        WA3D         = wa;
        RegWriteD    = rw;
        MemtoRegD    = mtr;
        MultiD       = mul;
        BranchTakenE = br;
        exp_q.push_back({fwd, ctl});
        tag_q.push_back(tag);
        #2;
        obs  = {ForwardE, StallF, StallD, StallE, FlushD, FlushE, FlushM};
        expv = exp_q.pop_front();
        t    = tag_q.pop_front();
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", t, obs, expv);
        end
    endtask

    initial begin
        reset = 1'b1;
        RaD = '0; WA3D = '0; RegWriteD = 0; MemtoRegD = 0; MultiD = 0; BranchTakenE = 0;

        //   rst ra0 ra1 wa  rw mtr mul br  fwd      ctl
        step(1, 0, 0, 1, 1, 1, 1, 1, 4'b0000, C_NONE, "reset_forces_zero");
        // back-to-back dependency
        step(0, 0, 0, 1, 1, 0, 0, 0, 4'b0000, C_NONE, "b2b_add_in_d");
        step(0, 1, 0, 2, 1, 0, 0, 0, 4'b0000, C_NONE, "b2b_sub_in_d");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, C_NONE, "b2b_fwd_m");
        // distance-2 and M-over-W priority
        step(0, 0, 0, 4, 1, 0, 0, 0, 4'b0000, C_NONE, "d2_prod_r4");
        step(0, 0, 0, 6, 1, 0, 0, 0, 4'b0000, C_NONE, "d2_filler_r6");
        step(0, 0, 4, 4, 1, 0, 0, 0, 4'b0000, C_NONE, "d2_cons_in_d");
        step(0, 4, 6, 9, 1, 0, 0, 0, 4'b0100, C_NONE, "d2_fwd_w");
        step(0, 0, 0, 10, 1, 0, 0, 0, 4'b0110, C_NONE, "mixed_m_and_w");
        step(0, 0, 0, 10, 1, 0, 0, 0, 4'b0000, C_NONE, "prio_p2_in_d");
        step(0, 10, 10, 11, 1, 0, 0, 0, 4'b0000, C_NONE, "prio_cons_in_d");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, C_NONE, "prio_m_beats_w");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, C_NONE, "drain");
        // load-use
        step(0, 0, 0, 3, 1, 1, 0, 0, 4'b0000, C_NONE, "lu_load_in_d");
        step(0, 0, 3, 12, 1, 0, 0, 0, 4'b0000, C_LW,   "lu_stall");
        step(0, 0, 3, 12, 1, 0, 0, 0, 4'b0000, C_NONE, "lu_released");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0100, C_NONE, "lu_fwd_w");
        // multi-cycle op (branch input ignored while busy)
        step(0, 0, 0, 5, 1, 0, 1, 0, 4'b0000, C_NONE, "mul_in_d");
        step(0, 5, 0, 13, 1, 0, 0, 1, 4'b0000, C_BUSY, "mul_busy1_br_ignored");
        step(0, 5, 0, 13, 1, 0, 0, 0, 4'b0000, C_BUSY, "mul_busy2");
        step(0, 5, 0, 13, 1, 0, 0, 0, 4'b0000, C_NONE, "mul_done");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, C_NONE, "mul_fwd_m");
        // taken branch together with load-use
        step(0, 0, 0, 7, 1, 1, 0, 0, 4'b0000, C_NONE, "brlu_load_in_d");
        step(0, 7, 0, 14, 1, 0, 0, 1, 4'b0000, C_BRLW, "brlu_flush_stall");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, C_NONE, "brlu_e_is_bubble");
        // zero register never matches
        step(0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, C_NONE, "zr_add_r0");
        step(0, 0, 0, 0, 1, 1, 0, 0, 4'b0000, C_NONE, "zr_load_r0");
        step(0, 0, 0, 15, 1, 0, 0, 0, 4'b0000, C_NONE, "zr_no_lwstall");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, C_NONE, "zr_no_forward");
        // reset in the middle of a busy period
        step(0, 0, 0, 5, 1, 0, 1, 0, 4'b0000, C_NONE, "rb_mul_in_d");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, C_BUSY, "rb_busy");
        step(1, 5, 0, 0, 0, 0, 0, 1, 4'b0000, C_NONE, "rb_reset_mid_busy");
        step(0, 0, 0, 2, 1, 1, 0, 0, 4'b0000, C_NONE, "rb_cnt_cleared");
        step(0, 0, 2, 8, 1, 0, 0, 0, 4'b0000, C_LW,   "rb_fresh_load");

        n_cmp++;
        assert (exp_q.size() === 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
